// File: rtl/sync_data_memory.sv
// sync_data_memory
// Single-port synchronous data memory with a valid/ready request port,
// byte-lane write masking, a READ_LATENCY-deep read response pipeline and a
// clear engine that zeroes the whole array after reset and on demand.
// Requests are refused while a clear is running.

module sync_data_memory #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    input  logic                    clear_start,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_next_s;
    logic                    ready_r;
    logic                    busy_r;
    logic                    rd_accept_s;
    logic                    wr_accept_s;

    // The array has no reset; the clear engine is the only source of zeroes.
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    // Stage i holds a read that was accepted i+1 edges ago. Data registers
    // only load when a valid read enters them, so the last stage holds the
    // most recent response between pulses.
    logic [READ_LATENCY-1:0] pipe_valid_r;
    logic [DATA_WIDTH-1:0]   pipe_data_r [READ_LATENCY];

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      mask
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    // ready_r mirrors the READY state, so acceptance never happens mid-clear.
    assign rd_accept_s = req_valid & ready_r & ~req_write;
    assign wr_accept_s = req_valid & ready_r & req_write;

    // Next-state logic: walk the clear counter up to the last address, and
    // restart it from zero when a clear is requested while serving.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                clr_cnt_next_s = clr_cnt_r + ADDR_WIDTH'(1'b1);
                if (clr_cnt_r == LAST_ADDR) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                if (clear_start) begin
                    state_next_s   = ST_CLEAR;
                    clr_cnt_next_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_next_s   = ST_READY;
                    clr_cnt_next_s = clr_cnt_r;
                end
            end
            default: begin
                state_next_s   = ST_CLEAR;
                clr_cnt_next_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // State register plus registered ready/busy flags derived from next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_WIDTH{1'b0}};
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
            ready_r   <= (state_next_s == ST_READY);
            busy_r    <= (state_next_s == ST_CLEAR);
        end
    end

    // Array write port: clear engine zeroes one word per edge, otherwise an
    // accepted write updates only its enabled byte lanes.
    always_ff @(posedge clock) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
        end else if (wr_accept_s) begin
            mem_r[req_addr] <= merge_lanes(mem_r[req_addr], req_wdata, req_wmask);
        end
    end

    // Read response pipeline: sample the array at the accepting edge, then
    // shift valid/data one stage per edge; reset drops anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid_r <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            pipe_valid_r[0] <= rd_accept_s;
            if (rd_accept_s) begin
                pipe_data_r[0] <= mem_r[req_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                if (pipe_valid_r[i-1]) begin
                    pipe_data_r[i] <= pipe_data_r[i-1];
                end
            end
        end
    end

    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign rsp_valid = pipe_valid_r[READ_LATENCY-1];
    assign rsp_data  = pipe_data_r[READ_LATENCY-1];

endmodule

// File: tb/tb_sync_data_memory.sv
// Testbench for sync_data_memory. Two instances share one stimulus stream:
// dut_a with READ_LATENCY = 3 and dut_b with READ_LATENCY = 2. A behavioural
// model (word array + per-cycle expected-response tables) predicts every
// response pulse, the held response data and the ready/busy flags.

module tb_sync_data_memory;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int NS    = 1024;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [1:0]    req_wmask;
    logic          clear_start;

    logic          ready_a, rsp_valid_a, busy_a;
    logic [DW-1:0] rsp_data_a;
    logic          ready_b, rsp_valid_b, busy_b;
    logic [DW-1:0] rsp_data_b;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int ready_at   = 1000000000;

    logic [DW-1:0] mem_model [DEPTH];
    bit            exp_va [NS];
    bit            exp_vb [NS];
    logic [DW-1:0] exp_da [NS];
    logic [DW-1:0] exp_db [NS];
    logic [DW-1:0] last_a;
    logic [DW-1:0] last_b;

    sync_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut_a (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .clear_start(clear_start), .rsp_valid(rsp_valid_a),
        .rsp_data(rsp_data_a), .busy(busy_a)
    );

    sync_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .clear_start(clear_start), .rsp_valid(rsp_valid_b),
        .rsp_data(rsp_data_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    // Edge counter: after rising edge k, cyc == k.
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every falling edge out of reset, compare responses and flags.
    always @(negedge clock) begin : monitor
        int            idx;
        logic [DW-1:0] want;
        bit            rdy;
        if (reset_n === 1'b1) begin
            idx = cyc % NS;
            vectors += 1;
            if (rsp_valid_a !== exp_va[idx]) begin
                miscompares += 1;
                $display("FAIL rsp_valid_a cyc=%0d got=%b want=%b", cyc, rsp_valid_a, exp_va[idx]);
            end
            want = exp_va[idx] ? exp_da[idx] : last_a;
            vectors += 1;
            if (rsp_data_a !== want) begin
                miscompares += 1;
                $display("FAIL rsp_data_a cyc=%0d got=%h want=%h", cyc, rsp_data_a, want);
            end
            last_a = want;
            exp_va[idx] = 1'b0;

            vectors += 1;
            if (rsp_valid_b !== exp_vb[idx]) begin
                miscompares += 1;
                $display("FAIL rsp_valid_b cyc=%0d got=%b want=%b", cyc, rsp_valid_b, exp_vb[idx]);
            end
            want = exp_vb[idx] ? exp_db[idx] : last_b;
            vectors += 1;
            if (rsp_data_b !== want) begin
                miscompares += 1;
                $display("FAIL rsp_data_b cyc=%0d got=%h want=%h", cyc, rsp_data_b, want);
            end
            last_b = want;
            exp_vb[idx] = 1'b0;

            rdy = (cyc >= ready_at);
            vectors += 1;
            if (ready_a !== rdy || ready_b !== rdy || busy_a !== !rdy || busy_b !== !rdy) begin
                miscompares += 1;
                $display("FAIL ready_busy cyc=%0d got=%b%b%b%b want ready=%b busy=%b",
                         cyc, ready_a, ready_b, busy_a, busy_b, rdy, !rdy);
            end
        end
    end

    // Drive one cycle of stimulus (called at negedge+1) and update the model.
    task automatic issue(input bit v, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] m, input bit clr);
        req_valid   = v;
        req_write   = w;
        req_addr    = a;
        req_wdata   = d;
        req_wmask   = m;
        clear_start = clr;
        if (cyc >= ready_at) begin
            if (v && w) begin
                if (m[0]) mem_model[a][7:0]  = d[7:0];
                if (m[1]) mem_model[a][15:8] = d[15:8];
            end else if (v) begin
                exp_va[(cyc + 3) % NS] = 1'b1;
                exp_da[(cyc + 3) % NS] = mem_model[a];
                exp_vb[(cyc + 2) % NS] = 1'b1;
                exp_db[(cyc + 2) % NS] = mem_model[a];
            end
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'h0000;
                ready_at = cyc + 33;
            end
        end
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 5'd0, 16'h0000, 2'b00, 1'b0);
    endtask

    // Hold reset for the given cycles; release leaves a 32-edge clear ahead.
    task automatic apply_reset(input int hold);
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        clear_start = 1'b0;
        for (int i = 0; i < NS; i++) begin
            exp_va[i] = 1'b0;
            exp_vb[i] = 1'b0;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            #1;
        end
        reset_n  = 1'b1;
        ready_at = cyc + 32;
        last_a   = 16'h0000;
        last_b   = 16'h0000;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'h0000;
    endtask

    task automatic test_reset();
        int rel;
        int n;
        int pulses;
        logic [DW-1:0] ored;
        apply_reset(2);
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin idle(); n++; end
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, AW'(i * 3), DW'($urandom), 2'b11, 1'b0);
        apply_reset(3);
        rel = cyc;
        vectors += 1;
        if (busy_a !== 1'b1 || ready_a !== 1'b0) begin
            miscompares += 1;
            $display("FAIL reset_flags busy=%b ready=%b want busy=1 ready=0", busy_a, ready_a);
        end
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin idle(); n++; end
        vectors += 1;
        if (cyc - rel !== 32) begin
            miscompares += 1;
            $display("FAIL reset_clear_len got=%0d want=32", cyc - rel);
        end
        pulses = 0;
        ored   = 16'h0000;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) issue(1'b1, 1'b0, AW'(i), 16'h0000, 2'b00, 1'b0);
            else idle();
            if (rsp_valid_b === 1'b1) begin
                pulses++;
                ored = ored | rsp_data_b;
            end
        end
        vectors += 1;
        if (pulses !== DEPTH || ored !== 16'h0000) begin
            miscompares += 1;
            $display("FAIL reset_readback pulses=%0d or=%h want pulses=32 or=0000", pulses, ored);
        end
    endtask

    task automatic test_write_read_latency();
        bit            want_v [5];
        want_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        issue(1'b1, 1'b1, 5'd7, 16'hBEEF, 2'b11, 1'b0);
        issue(1'b1, 1'b0, 5'd7, 16'h0000, 2'b00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            vectors += 1;
            if (rsp_valid_a !== want_v[k] || (k >= 2 && rsp_data_a !== 16'hBEEF)) begin
                miscompares += 1;
                $display("FAIL latency3 step=%0d got v=%b d=%h want v=%b d=beef",
                         k, rsp_valid_a, rsp_data_a, want_v[k]);
            end
            idle();
        end
    endtask

    task automatic test_byte_mask();
        issue(1'b1, 1'b1, 5'd3, 16'h1234, 2'b11, 1'b0);
        issue(1'b1, 1'b1, 5'd3, 16'hABCD, 2'b01, 1'b0);
        issue(1'b1, 1'b0, 5'd3, 16'h0000, 2'b00, 1'b0);
        idle();
        vectors += 1;
        if (rsp_valid_b !== 1'b1 || rsp_data_b !== 16'h12CD) begin
            miscompares += 1;
            $display("FAIL byte_mask got v=%b d=%h want v=1 d=12cd", rsp_valid_b, rsp_data_b);
        end
        issue(1'b1, 1'b1, 5'd3, 16'hFFFF, 2'b00, 1'b0);
        issue(1'b1, 1'b0, 5'd3, 16'h0000, 2'b00, 1'b0);
        idle();
        vectors += 1;
        if (rsp_data_b !== 16'h12CD) begin
            miscompares += 1;
            $display("FAIL zero_mask got=%h want=12cd", rsp_data_b);
        end
        idle();
    endtask

    task automatic test_pipelined();
        logic [DW-1:0] got [$];
        int            first;
        int            lastc;
        for (int i = 0; i < 5; i++) issue(1'b1, 1'b1, AW'(i), DW'(16'h0010 + i), 2'b11, 1'b0);
        first = -1;
        lastc = -1;
        for (int s = 0; s < 10; s++) begin
            if (s < 5) issue(1'b1, 1'b0, AW'(s), 16'h0000, 2'b00, 1'b0);
            else idle();
            if (rsp_valid_b === 1'b1) begin
                got.push_back(rsp_data_b);
                if (first < 0) first = cyc;
                lastc = cyc;
            end
        end
        vectors += 1;
        if (got.size() !== 5 || lastc - first !== 4) begin
            miscompares += 1;
            $display("FAIL pipelined_count got=%0d span=%0d want 5 span 4", got.size(), lastc - first);
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors += 1;
            if (got[i] !== DW'(16'h0010 + i)) begin
                miscompares += 1;
                $display("FAIL pipelined_data idx=%0d got=%h want=%h", i, got[i], DW'(16'h0010 + i));
            end
        end
    endtask

    task automatic test_runtime_clear();
        int            low;
        bit            seen;
        logic [DW-1:0] d;
        issue(1'b1, 1'b1, 5'd5, 16'h5555, 2'b11, 1'b0);
        issue(1'b1, 1'b0, 5'd5, 16'h0000, 2'b00, 1'b1);
        low  = 0;
        seen = 1'b0;
        d    = 16'h0000;
        while (ready_a !== 1'b1 && low < 100) begin
            if (rsp_valid_b === 1'b1) begin seen = 1'b1; d = rsp_data_b; end
            low++;
            idle();
        end
        vectors += 1;
        if (low !== 32) begin
            miscompares += 1;
            $display("FAIL clear_ready_low got=%0d want=32", low);
        end
        vectors += 1;
        if (!seen || d !== 16'h5555) begin
            miscompares += 1;
            $display("FAIL clear_preread got seen=%b d=%h want 5555", seen, d);
        end
        issue(1'b1, 1'b0, 5'd5, 16'h0000, 2'b00, 1'b0);
        idle();
        vectors += 1;
        if (rsp_valid_b !== 1'b1 || rsp_data_b !== 16'h0000) begin
            miscompares += 1;
            $display("FAIL clear_postread got v=%b d=%h want v=1 d=0000", rsp_valid_b, rsp_data_b);
        end
        idle();
    endtask

    task automatic test_reset_midop();
        int rel;
        int n;
        int pulses;
        issue(1'b1, 1'b1, 5'd9, 16'h9999, 2'b11, 1'b0);
        issue(1'b1, 1'b0, 5'd9, 16'h0000, 2'b00, 1'b0);
        apply_reset(1);
        rel = cyc;
        pulses = 0;
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin
            if (rsp_valid_a === 1'b1 || rsp_valid_b === 1'b1) pulses++;
            idle();
            n++;
        end
        vectors += 1;
        if (pulses !== 0 || cyc - rel !== 32) begin
            miscompares += 1;
            $display("FAIL reset_inflight pulses=%0d len=%0d want 0 and 32", pulses, cyc - rel);
        end
        issue(1'b1, 1'b1, 5'd9, 16'h9999, 2'b11, 1'b0);
        issue(1'b1, 1'b0, 5'd0, 16'h0000, 2'b00, 1'b1);
        for (int k = 0; k < 20; k++) idle();
        apply_reset(2);
        rel = cyc;
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin idle(); n++; end
        vectors += 1;
        if (cyc - rel !== 32) begin
            miscompares += 1;
            $display("FAIL reset_midclear_len got=%0d want=32", cyc - rel);
        end
        issue(1'b1, 1'b0, 5'd9, 16'h0000, 2'b00, 1'b0);
        idle();
        vectors += 1;
        if (rsp_valid_b !== 1'b1 || rsp_data_b !== 16'h0000) begin
            miscompares += 1;
            $display("FAIL reset_midclear_read got v=%b d=%h want v=1 d=0000", rsp_valid_b, rsp_data_b);
        end
        idle();
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 400; k++) begin
            issue(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
                  2'($urandom), ($urandom_range(0, 99) == 0));
        end
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin idle(); n++; end
        vectors += 1;
        if (ready_a !== 1'b1) begin
            miscompares += 1;
            $display("FAIL random_ready_timeout got=%b want=1", ready_a);
        end
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 1'b0, AW'(i), 16'h0000, 2'b00, 1'b0);
            idle();
            vectors += 1;
            if (rsp_valid_b !== 1'b1 || rsp_data_b !== mem_model[i]) begin
                miscompares += 1;
                $display("FAIL random_readback addr=%0d got v=%b d=%h want v=1 d=%h",
                         i, rsp_valid_b, rsp_data_b, mem_model[i]);
            end
        end
        for (int k = 0; k < 4; k++) idle();
    endtask

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 5'd0;
        req_wdata   = 16'h0000;
        req_wmask   = 2'b00;
        clear_start = 1'b0;
        last_a      = 16'h0000;
        last_b      = 16'h0000;
        @(negedge clock);
        #1;
        test_reset();
        test_write_read_latency();
        test_byte_mask();
        test_pipelined();
        test_runtime_clear();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
